// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: prioritised stall/flush/freeze sequencer for the 5-stage pipeline.
// Drives per-stage write enables, flush and bubble controls, tracks the current
// action, keeps saturating performance counters and a sticky stall watchdog.
// Optional feature macro: DELAY_SLOT_EN (JR redirect keeps the delay-slot instruction).
module pipe_seq_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WDOG_MAX = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_stall,
    input  logic             jr_taken,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             pc_sel_br,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             wdog_err
);

    localparam int unsigned RUN_W = $clog2(WDOG_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t           action;
    state_t           state_q;
    logic             is_br;
    logic [RUN_W-1:0] run_len;

    assign state = state_q;

    // Classify the current cycle by priority: freeze > branch > stall > jr > run
    always_comb begin
        action = ST_RUN;
        is_br  = 1'b0;
        if (mem_busy) begin
            action = ST_FREEZE;
        end else if (br_taken) begin
            action = ST_FLUSH;
            is_br  = 1'b1;
        end else if (hz_stall) begin
            action = ST_STALL;
        end else if (jr_taken) begin
            action = ST_FLUSH;
        end
    end

    // Decode the action into per-stage controls; reset forces a safe hold-and-clear
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        pc_sel_br   = 1'b0;
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b0;
            memwb_we    = 1'b0;
        end else begin
            case (action)
                ST_FREEZE: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    exmem_we = 1'b0;
                    memwb_we = 1'b0;
                end
                ST_STALL: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
                ST_FLUSH: begin
                    pc_sel_br   = is_br;
                    idex_bubble = is_br;
`ifdef DELAY_SLOT_EN
                    // Delay slot already sits in ID on a branch; on JR it is in IF and survives
                    ifid_flush  = is_br;
`else
                    ifid_flush  = 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Action register, saturating counters and stall watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            stall_cycles  <= '0;
            freeze_cycles <= '0;
            flush_count   <= '0;
            run_len       <= '0;
            wdog_err      <= 1'b0;
        end else begin
            state_q <= action;
            if (action == ST_STALL && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (action == ST_FREEZE && freeze_cycles != '1) begin
                freeze_cycles <= freeze_cycles + CNT_W'(1);
            end
            if (action == ST_FLUSH && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (action == ST_STALL || action == ST_FREEZE) begin
                if (run_len != RUN_W'(WDOG_MAX)) begin
                    run_len <= run_len + RUN_W'(1);
                end
                if (run_len == RUN_W'(WDOG_MAX - 1)) begin
                    wdog_err <= 1'b1;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule
